// File: rtl/execute_stage_md_if.sv
// Execute-stage pipeline bundle: ID/EX operands and controls in,
// redirect, stall request and EX/MEM register out.
interface execute_stage_md_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5
);
  logic            stall_i;
  logic            flush_i;
  logic            valid_e;
  logic            reg_write_e;
  logic            mem_write_e;
  logic            alu_src_e;
  logic            branch_e;
  logic            jump_e;
  logic            jalr_e;
  logic            md_en_e;
  logic [1:0]      result_src_e;
  logic [3:0]      alu_ctrl_e;
  logic [2:0]      br_cond_e;
  logic [2:0]      md_op_e;
  logic [XLEN-1:0] rd1_e;
  logic [XLEN-1:0] rd2_e;
  logic [XLEN-1:0] imm_e;
  logic [XLEN-1:0] pc_e;
  logic [XLEN-1:0] pc_plus4_e;
  logic [XLEN-1:0] result_w;
  logic [REGW-1:0] rd_e;
  logic [1:0]      forward_a_e;
  logic [1:0]      forward_b_e;
  logic            md_busy_o;
  logic            pc_src_o;
  logic [XLEN-1:0] pc_target_o;
  logic            valid_m;
  logic            reg_write_m;
  logic            mem_write_m;
  logic [1:0]      result_src_m;
  logic [REGW-1:0] rd_m;
  logic [XLEN-1:0] alu_result_m;
  logic [XLEN-1:0] write_data_m;
  logic [XLEN-1:0] pc_plus4_m;

  modport master (
    output stall_i, flush_i, valid_e, reg_write_e, mem_write_e,
    output alu_src_e, branch_e, jump_e, jalr_e, md_en_e,
    output result_src_e, alu_ctrl_e, br_cond_e, md_op_e,
    output rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e, result_w,
    output rd_e, forward_a_e, forward_b_e,
    input  md_busy_o, pc_src_o, pc_target_o,
    input  valid_m, reg_write_m, mem_write_m, result_src_m,
    input  rd_m, alu_result_m, write_data_m, pc_plus4_m
  );

  modport slave (
    input  stall_i, flush_i, valid_e, reg_write_e, mem_write_e,
    input  alu_src_e, branch_e, jump_e, jalr_e, md_en_e,
    input  result_src_e, alu_ctrl_e, br_cond_e, md_op_e,
    input  rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e, result_w,
    input  rd_e, forward_a_e, forward_b_e,
    output md_busy_o, pc_src_o, pc_target_o,
    output valid_m, reg_write_m, mem_write_m, result_src_m,
    output rd_m, alu_result_m, write_data_m, pc_plus4_m
  );
endinterface

// File: rtl/execute_stage_md.sv
// Execute stage: ALU, forwarding, branch resolution, iterative
// multiply/divide and the EX/MEM pipeline register.
module execute_stage_md #(
  parameter int XLEN       = 32,
  parameter int REGW       = 5,
  parameter int MUL_CYCLES = 2
) (
  input logic               clk,
  input logic               rst_n,
  execute_stage_md_if.slave ex
);
  localparam int SHW  = $clog2(XLEN);
  localparam int CMAX = (XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_e;

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d;

  logic            valid_m_q, valid_m_d;
  logic            reg_write_m_q, reg_write_m_d;
  logic            mem_write_m_q, mem_write_m_d;
  logic [1:0]      result_src_m_q, result_src_m_d;
  logic [REGW-1:0] rd_m_q, rd_m_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;

  logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b, alu_res;
  logic [SHW-1:0]  shamt;
  logic            taken, start, busy, done;

  // Operand forwarding muxes
  always_comb begin
    fwd_a = ex.rd1_e;
    fwd_b = ex.rd2_e;
    case (ex.forward_a_e)
      2'b01:   fwd_a = ex.result_w;
      2'b10:   fwd_a = alu_result_q;
      default: fwd_a = ex.rd1_e;
    endcase
    case (ex.forward_b_e)
      2'b01:   fwd_b = ex.result_w;
      2'b10:   fwd_b = alu_result_q;
      default: fwd_b = ex.rd2_e;
    endcase
  end

  assign src_a = fwd_a;
  assign src_b = ex.alu_src_e ? ex.imm_e : fwd_b;
  assign shamt = src_b[SHW-1:0];

  // Single-cycle ALU
  always_comb begin
    alu_res = '0;
    case (ex.alu_ctrl_e)
      4'd0: alu_res = src_a + src_b;
      4'd1: alu_res = src_a - src_b;
      4'd2: alu_res = src_a & src_b;
      4'd3: alu_res = src_a | src_b;
      4'd4: alu_res = src_a ^ src_b;
      4'd5: alu_res = {{(XLEN-1){1'b0}},
                       $signed(src_a) < $signed(src_b)};
      4'd6: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      4'd7: alu_res = src_a << shamt;
      4'd8: alu_res = src_a >> shamt;
      4'd9: alu_res = $signed(src_a) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // Branch condition on forwarded register operands
  always_comb begin
    taken = 1'b0;
    case (ex.br_cond_e)
      3'b000:  taken = (fwd_a == fwd_b);
      3'b001:  taken = (fwd_a != fwd_b);
      3'b100:  taken = $signed(fwd_a) < $signed(fwd_b);
      3'b101:  taken = !($signed(fwd_a) < $signed(fwd_b));
      3'b110:  taken = fwd_a < fwd_b;
      3'b111:  taken = !(fwd_a < fwd_b);
      default: taken = 1'b0;
    endcase
  end

  assign ex.pc_target_o = ex.jalr_e
    ? ((src_a + ex.imm_e) & {{(XLEN-1){1'b1}}, 1'b0})
    : (ex.pc_e + ex.imm_e);
  assign ex.pc_src_o = ex.valid_e & ~ex.flush_i &
                       (ex.jump_e | (ex.branch_e & taken));

  // Divider datapath: magnitudes, one restoring step per cycle
  logic            dsgn, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] dvs_mag, quo_fix, rem_fix;
  logic [XLEN:0]   shl, diff;

  assign dsgn    = ~op_q[0];
  assign a_neg   = dsgn & a_q[XLEN-1];
  assign b_neg   = dsgn & b_q[XLEN-1];
  assign dvs_mag = b_neg ? -b_q : b_q;
  assign shl     = {rem_q, quo_q[XLEN-1]};
  assign diff    = shl - {1'b0, dvs_mag};
  assign div0    = (b_q == '0);
  assign ovf     = dsgn & (a_q == {1'b1, {(XLEN-1){1'b0}}}) &
                   (b_q == '1);

  // Sign fix-up and special cases once the divide has run
  always_comb begin
    quo_fix = (a_neg ^ b_neg) ? -quo_q : quo_q;
    rem_fix = a_neg ? -rem_q : rem_q;
    if (div0) begin
      quo_fix = '1;
      rem_fix = a_q;
    end else if (ovf) begin
      quo_fix = a_q;
      rem_fix = '0;
    end
  end

  // Multiplier on latched operands, sign-extended per op
  logic [2*XLEN-1:0] ext_a, ext_b, prod;
  logic [XLEN-1:0]   md_res;

  assign ext_a = {{XLEN{a_q[XLEN-1] & (op_q[1:0] != 2'b11)}}, a_q};
  assign ext_b = {{XLEN{b_q[XLEN-1] & ~op_q[1]}}, b_q};
  assign prod  = ext_a * ext_b;

  // Select the M/D result by latched opcode
  always_comb begin
    md_res = prod[XLEN-1:0];
    if (op_q[2])
      md_res = op_q[1] ? rem_fix : quo_fix;
    else if (op_q[1:0] != 2'b00)
      md_res = prod[2*XLEN-1:XLEN];
  end

  assign start = ex.valid_e & ex.md_en_e & ~ex.flush_i;
  assign busy  = ((state_q == IDLE) & start) |
                 (state_q == MUL) | (state_q == DIV);
  assign done  = (state_q == DONE);
  assign ex.md_busy_o = busy;

  // M/D sequencer next state and datapath updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ex.md_op_e[2] ? DIV : MUL;
          cnt_d   = '0;
          op_d    = ex.md_op_e;
          a_d     = fwd_a;
          b_d     = fwd_b;
          quo_d   = (~ex.md_op_e[0] & fwd_a[XLEN-1]) ? -fwd_a : fwd_a;
          rem_d   = '0;
        end
      end
      MUL: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(MUL_CYCLES - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DIV: begin
        cnt_d = cnt_q + CW'(1);
        if (!diff[XLEN]) begin
          rem_d = diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = shl[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        if (!ex.stall_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (ex.flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // EX/MEM register: flush > stall > busy bubble > load
  always_comb begin
    valid_m_d      = valid_m_q;
    reg_write_m_d  = reg_write_m_q;
    mem_write_m_d  = mem_write_m_q;
    result_src_m_d = result_src_m_q;
    rd_m_d         = rd_m_q;
    alu_result_d   = alu_result_q;
    write_data_d   = write_data_q;
    pc_plus4_d     = pc_plus4_q;
    if (ex.flush_i || (!ex.stall_i && busy)) begin
      valid_m_d     = 1'b0;
      reg_write_m_d = 1'b0;
      mem_write_m_d = 1'b0;
    end else if (!ex.stall_i) begin
      valid_m_d      = ex.valid_e;
      reg_write_m_d  = ex.reg_write_e;
      mem_write_m_d  = ex.mem_write_e;
      result_src_m_d = ex.result_src_e;
      rd_m_d         = ex.rd_e;
      alu_result_d   = done ? md_res : alu_res;
      write_data_d   = fwd_b;
      pc_plus4_d     = ex.pc_plus4_e;
    end
  end

  // State and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      op_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      quo_q          <= '0;
      rem_q          <= '0;
      valid_m_q      <= 1'b0;
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      result_src_m_q <= '0;
      rd_m_q         <= '0;
      alu_result_q   <= '0;
      write_data_q   <= '0;
      pc_plus4_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      op_q           <= op_d;
      a_q            <= a_d;
      b_q            <= b_d;
      quo_q          <= quo_d;
      rem_q          <= rem_d;
      valid_m_q      <= valid_m_d;
      reg_write_m_q  <= reg_write_m_d;
      mem_write_m_q  <= mem_write_m_d;
      result_src_m_q <= result_src_m_d;
      rd_m_q         <= rd_m_d;
      alu_result_q   <= alu_result_d;
      write_data_q   <= write_data_d;
      pc_plus4_q     <= pc_plus4_d;
    end
  end

  assign ex.valid_m      = valid_m_q;
  assign ex.reg_write_m  = reg_write_m_q;
  assign ex.mem_write_m  = mem_write_m_q;
  assign ex.result_src_m = result_src_m_q;
  assign ex.rd_m         = rd_m_q;
  assign ex.alu_result_m = alu_result_q;
  assign ex.write_data_m = write_data_q;
  assign ex.pc_plus4_m   = pc_plus4_q;
endmodule

// File: tb/tb_execute_stage_md.sv
// Directed bench for execute_stage_md: ALU, forwarding, branches,
// multiply/divide latency and results, stall/flush/reset behaviour.
module tb_execute_stage_md;
  localparam int XLEN = 32;
  localparam int REGW = 5;
  localparam int MULC = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  execute_stage_md_if #(.XLEN(XLEN), .REGW(REGW)) bus ();

  execute_stage_md #(
    .XLEN(XLEN), .REGW(REGW), .MUL_CYCLES(MULC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ex(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.stall_i      = 1'b0;
    bus.flush_i      = 1'b0;
    bus.valid_e      = 1'b0;
    bus.reg_write_e  = 1'b0;
    bus.mem_write_e  = 1'b0;
    bus.alu_src_e    = 1'b0;
    bus.branch_e     = 1'b0;
    bus.jump_e       = 1'b0;
    bus.jalr_e       = 1'b0;
    bus.md_en_e      = 1'b0;
    bus.result_src_e = 2'b00;
    bus.alu_ctrl_e   = 4'd0;
    bus.br_cond_e    = 3'd0;
    bus.md_op_e      = 3'd0;
    bus.rd1_e        = '0;
    bus.rd2_e        = '0;
    bus.imm_e        = '0;
    bus.pc_e         = '0;
    bus.pc_plus4_e   = '0;
    bus.result_w     = '0;
    bus.rd_e         = '0;
    bus.forward_a_e  = 2'b00;
    bus.forward_b_e  = 2'b00;
  endtask

  task automatic set_md(input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    clr();
    bus.valid_e     = 1'b1;
    bus.md_en_e     = 1'b1;
    bus.reg_write_e = 1'b1;
    bus.rd_e        = 5'd9;
    bus.md_op_e     = op;
    bus.rd1_e       = a;
    bus.rd2_e       = b;
  endtask

  task automatic run_md(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int nb_exp);
    int nb = 0;
    int ne = 0;
    int nv = 0;
    logic got = 1'b0;
    logic [31:0] res = '0;
    logic [4:0] rdm = '0;
    set_md(op, a, b);
    for (int i = 0; i < 100 && !got; i++) begin
      #1;
      if (bus.md_busy_o) nb++;
      @(posedge clk);
      #1;
      ne++;
      if (bus.valid_m) begin
        got = 1'b1;
        res = bus.alu_result_m;
        rdm = bus.rd_m;
      end
    end
    clr();
    chk({tag, "_valid"}, got, 1);
    chk({tag, "_busy"}, nb, nb_exp);
    chk({tag, "_lat"}, ne, nb_exp + 1);
    chk({tag, "_res"}, res, exp);
    chk({tag, "_rd"}, rdm, 9);
    for (int i = 0; i < 2; i++) begin
      tick();
      if (bus.valid_m) nv++;
    end
    chk({tag, "_once"}, nv, 0);
  endtask

  logic [3:0]  t_ctrl [8] = '{4'd1, 4'd9, 4'd8, 4'd7,
                              4'd5, 4'd6, 4'd4, 4'd12};
  logic [31:0] t_a [8] = '{32'd3, 32'h80000000, 32'h80000000, 32'd1,
                           32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0, 32'd5};
  logic [31:0] t_b [8] = '{32'd5, 32'd4, 32'd4, 32'd33,
                           32'd1, 32'd1, 32'hFF, 32'd5};
  logic [31:0] t_e [8] = '{32'hFFFFFFFE, 32'hF8000000, 32'h08000000,
                           32'd2, 32'd1, 32'd0, 32'h0F, 32'd0};

  initial begin
    int nv;
    clr();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", bus.valid_m, 0);
    chk("rst_busy", bus.md_busy_o, 0);
    chk("rst_alu", bus.alu_result_m, 0);
    chk("rst_rd", bus.rd_m, 0);
    chk("rst_wd", bus.write_data_m, 0);
    #10 rst_n = 1'b1;
    tick();

    bus.valid_e      = 1'b1;
    bus.reg_write_e  = 1'b1;
    bus.rd_e         = 5'd7;
    bus.rd1_e        = 32'd2;
    bus.rd2_e        = 32'd3;
    bus.pc_plus4_e   = 32'h104;
    bus.result_src_e = 2'b01;
    tick();
    chk("add_res", bus.alu_result_m, 32'd5);
    chk("add_valid", bus.valid_m, 1);
    chk("add_rd", bus.rd_m, 7);
    chk("add_pc4", bus.pc_plus4_m, 32'h104);
    chk("add_rsrc", bus.result_src_m, 1);
    chk("add_rw", bus.reg_write_m, 1);

    bus.forward_a_e = 2'b10;
    bus.rd1_e       = 32'hDEAD;
    bus.rd2_e       = 32'd7;
    tick();
    chk("fwd_a_m", bus.alu_result_m, 32'd12);

    bus.forward_a_e = 2'b00;
    bus.rd1_e       = 32'h10;
    bus.alu_src_e   = 1'b1;
    bus.imm_e       = 32'd4;
    bus.forward_b_e = 2'b01;
    bus.result_w    = 32'd9;
    bus.rd2_e       = 32'hBEEF;
    bus.mem_write_e = 1'b1;
    bus.reg_write_e = 1'b0;
    tick();
    chk("st_addr", bus.alu_result_m, 32'h14);
    chk("fwd_b_w", bus.write_data_m, 32'd9);
    chk("st_mw", bus.mem_write_m, 1);
    chk("st_rw", bus.reg_write_m, 0);

    clr();
    bus.valid_e     = 1'b1;
    bus.reg_write_e = 1'b1;
    bus.rd1_e       = 32'd1;
    bus.rd2_e       = 32'd1;
    bus.stall_i     = 1'b1;
    tick();
    chk("stall_hold", bus.alu_result_m, 32'h14);
    chk("stall_mw", bus.mem_write_m, 1);
    bus.stall_i = 1'b0;
    tick();
    chk("stall_rel", bus.alu_result_m, 32'd2);
    chk("stall_rel_mw", bus.mem_write_m, 0);

    bus.flush_i = 1'b1;
    bus.stall_i = 1'b1;
    bus.rd1_e   = 32'd5;
    tick();
    chk("flush_valid", bus.valid_m, 0);
    chk("flush_rw", bus.reg_write_m, 0);

    for (int i = 0; i < 8; i++) begin
      clr();
      bus.valid_e     = 1'b1;
      bus.reg_write_e = 1'b1;
      bus.alu_ctrl_e  = t_ctrl[i];
      bus.rd1_e       = t_a[i];
      bus.rd2_e       = t_b[i];
      tick();
      chk($sformatf("alu_op%0d", t_ctrl[i]), bus.alu_result_m, t_e[i]);
    end

    clr();
    bus.valid_e   = 1'b1;
    bus.branch_e  = 1'b1;
    bus.pc_e      = 32'h100;
    bus.imm_e     = 32'h20;
    bus.rd1_e     = 32'd3;
    bus.rd2_e     = 32'd3;
    bus.br_cond_e = 3'b000;
    #1;
    chk("beq_src", bus.pc_src_o, 1);
    chk("beq_tgt", bus.pc_target_o, 32'h120);
    bus.br_cond_e = 3'b001;
    #1;
    chk("bne_src", bus.pc_src_o, 0);
    bus.br_cond_e = 3'b011;
    #1;
    chk("bundef_src", bus.pc_src_o, 0);
    bus.br_cond_e = 3'b000;
    bus.flush_i   = 1'b1;
    #1;
    chk("beq_flush", bus.pc_src_o, 0);
    bus.flush_i   = 1'b0;
    bus.rd1_e     = 32'hFFFFFFFF;
    bus.rd2_e     = 32'd1;
    bus.br_cond_e = 3'b100;
    #1;
    chk("blt_src", bus.pc_src_o, 1);
    bus.br_cond_e = 3'b110;
    #1;
    chk("bltu_src", bus.pc_src_o, 0);
    tick();

    clr();
    bus.valid_e = 1'b1;
    bus.jump_e  = 1'b1;
    bus.jalr_e  = 1'b1;
    bus.pc_e    = 32'h100;
    bus.rd1_e   = 32'h1003;
    bus.imm_e   = 32'd4;
    #1;
    chk("jalr_tgt", bus.pc_target_o, 32'h1006);
    chk("jalr_src", bus.pc_src_o, 1);
    bus.jalr_e = 1'b0;
    #1;
    chk("jal_tgt", bus.pc_target_o, 32'h104);
    tick();
    clr();
    tick();

    run_md("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3);
    run_md("mul", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 3);
    run_md("mulh", 3'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 3);
    run_md("mulhsu", 3'd2, 32'd2, 32'hFFFFFFFF, 32'h00000001, 3);
    run_md("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_md("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_md("div_7_m2", 3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    run_md("rem_7_m2", 3'd6, 32'd7, 32'hFFFFFFFE, 32'd1, 33);
    run_md("divu_5_0", 3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 33);
    run_md("remu_5_0", 3'd7, 32'd5, 32'd0, 32'd5, 33);
    run_md("rem_m7_0", 3'd6, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 33);
    run_md("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    run_md("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33);
    run_md("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_md("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 33);

    set_md(3'd0, 32'd6, 32'd7);
    tick();
    bus.forward_a_e = 2'b01;
    bus.result_w    = 32'd100;
    tick();
    tick();
    chk("done_busy", bus.md_busy_o, 0);
    bus.stall_i = 1'b1;
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.valid_m) nv++;
    end
    chk("done_stall_nov", nv, 0);
    chk("done_stall_busy", bus.md_busy_o, 0);
    bus.stall_i = 1'b0;
    tick();
    chk("done_rel_valid", bus.valid_m, 1);
    chk("done_rel_res", bus.alu_result_m, 32'd42);
    clr();
    tick();
    chk("done_once", bus.valid_m, 0);

    set_md(3'd5, 32'd100, 32'd7);
    for (int i = 0; i < 11; i++) tick();
    chk("div_mid_busy", bus.md_busy_o, 1);
    bus.flush_i = 1'b1;
    tick();
    clr();
    #1;
    chk("flush_div_busy", bus.md_busy_o, 0);
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.valid_m) nv++;
    end
    chk("flush_div_nov", nv, 0);
    bus.valid_e = 1'b1;
    bus.rd1_e   = 32'd4;
    bus.rd2_e   = 32'd5;
    tick();
    chk("post_flush_add", bus.alu_result_m, 32'd9);
    chk("post_flush_v", bus.valid_m, 1);

    set_md(3'd4, 32'd100, 32'd7);
    for (int i = 0; i < 5; i++) tick();
    clr();
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", bus.md_busy_o, 0);
    chk("mrst_valid", bus.valid_m, 0);
    chk("mrst_alu", bus.alu_result_m, 0);
    chk("mrst_pc4", bus.pc_plus4_m, 0);
    chk("mrst_rd", bus.rd_m, 0);
    #3 rst_n = 1'b1;
    tick();
    bus.valid_e = 1'b1;
    bus.rd1_e   = 32'd1;
    bus.rd2_e   = 32'd2;
    tick();
    chk("post_rst_add", bus.alu_result_m, 32'd3);
    chk("post_rst_v", bus.valid_m, 1);
    chk("post_rst_busy", bus.md_busy_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
